output_pipeline_ctrl: RTL and testbench

Sequencer for the convolution engine's output data pipeline (a Stages-deep shift register with a single clock enable and no per-stage valid). Runs one frame of cfg_count results per start: accepts results via valid/ready, drives the pipeline enable, keeps a per-stage valid shadow, presents a valid/ready/last interface at the pipeline tail, and pulses done when the last result has been consumed. Sits between the MAC/accumulator result stage and the Avalon-side result sink.

---
 rtl/output_pipeline_ctrl_pkg.sv | 24 ++
 rtl/output_pipeline_ctrl_if.sv | 26 ++
 rtl/output_pipeline_ctrl_valid_shadow_pipe.sv | 35 +++
 rtl/output_pipeline_ctrl.sv | 104 ++++++++++
 tb/tb_output_pipeline_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/output_pipeline_ctrl_pkg.sv
// Shared definitions for the convolution engine's pipeline sequencers:
// state encoding and the legal pipeline depth range.
package output_pipeline_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 32;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_FLUSH = ST_FLUSH,
        S_DONE  = ST_DONE
    } state_t;

    function automatic logic state_is_busy(state_t s);
        return (s == S_RUN) || (s == S_FLUSH);
    endfunction

endpackage

// File: rtl/output_pipeline_ctrl_if.sv
// Frame control, upstream result handshake and pipeline-tail handshake
// of the output pipeline sequencer.
interface output_pipeline_ctrl_if #(
    parameter int CountWidth = 16
);
    logic                  start;
    logic [CountWidth-1:0] cfg_count;
    logic                  busy;
    logic                  done;
    logic                  in_valid;
    logic                  in_ready;
    logic                  pipe_en;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport slave (
        input  start, cfg_count, in_valid, out_ready,
        output busy, done, in_ready, pipe_en, out_valid, out_last
    );

    modport master (
        output start, cfg_count, in_valid, out_ready,
        input  busy, done, in_ready, pipe_en, out_valid, out_last
    );
endinterface

// File: rtl/output_pipeline_ctrl_valid_shadow_pipe.sv
// Valid shadow of the data pipeline: one bit per stage, shifted on the
// same enable as the data so it always mirrors the data pipeline.
module valid_shadow_pipe
    import output_pipeline_ctrl_pkg::*;
#(
    parameter int Stages = 5
) (
    input  logic              clk,
    input  logic              aclr_n,
    input  logic              en,
    input  logic              din,
    output logic [Stages-1:0] vld
);

    logic [Stages-1:0] vld_q;
    logic [Stages-1:0] vld_d;

    if (Stages < STAGES_MIN || Stages > STAGES_MAX) begin : g_bad_stages
        $error("valid_shadow_pipe: Stages out of legal range");
    end

    if (Stages == 1) begin : g_one
        always_comb vld_d = en ? din : vld_q;
    end else begin : g_multi
        always_comb vld_d = en ? {vld_q[Stages-2:0], din} : vld_q;
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) vld_q <= '0;
        else         vld_q <= vld_d;
    end

    assign vld = vld_q;

endmodule

// File: rtl/output_pipeline_ctrl.sv
// Output pipeline sequencer: runs one frame of cfg_count results through a
// Stages-deep enable-only data pipeline and reports frame completion.
module output_pipeline_ctrl
    import output_pipeline_ctrl_pkg::*;
#(
    parameter int Stages     = 5,
    parameter int CountWidth = 16
) (
    input  logic                  clk,
    input  logic                  aclr_n,
    output_pipeline_ctrl_if.slave bus
);

    state_t                state_q, state_d;
    logic [CountWidth-1:0] cfg_q, cfg_d;
    logic [CountWidth-1:0] acc_cnt_q, acc_cnt_d;
    logic [CountWidth-1:0] out_cnt_q, out_cnt_d;

    logic [Stages-1:0] vld;
    logic              out_valid;
    logic              out_last;
    logic              advance;
    logic              in_ready;
    logic              pipe_en;
    logic              in_hs;
    logic              out_hs;

    // A stalled tail freezes every stage; bubbles are never squeezed out.
    assign out_valid = vld[Stages-1];
    assign advance   = !out_valid || bus.out_ready;
    assign out_last  = out_valid && (out_cnt_q == cfg_q - CountWidth'(1));

    always_comb begin
        in_ready = 1'b0;
        pipe_en  = 1'b0;
        case (state_q)
            S_RUN: begin
                in_ready = advance && (acc_cnt_q < cfg_q);
                pipe_en  = advance;
            end
            S_FLUSH: pipe_en = advance && (|vld);
            default: ;
        endcase
    end

    assign in_hs  = bus.in_valid && in_ready;
    assign out_hs = out_valid && bus.out_ready;

    valid_shadow_pipe #(.Stages(Stages)) u_vld (
        .clk    (clk),
        .aclr_n (aclr_n),
        .en     (pipe_en),
        .din    (in_hs),
        .vld    (vld)
    );

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        acc_cnt_d = acc_cnt_q + CountWidth'(in_hs);
        out_cnt_d = out_cnt_q + CountWidth'(out_hs);
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cfg_d     = bus.cfg_count;
                    acc_cnt_d = '0;
                    out_cnt_d = '0;
                    state_d   = (bus.cfg_count != '0) ? S_RUN : S_DONE;
                end
            end
            // The last output can retire while still in RUN when Stages=1.
            S_RUN: begin
                if (out_hs && out_last)       state_d = S_DONE;
                else if (acc_cnt_q == cfg_q)  state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (out_hs && out_last) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q   <= S_IDLE;
            cfg_q     <= '0;
            acc_cnt_q <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            acc_cnt_q <= acc_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    assign bus.busy      = state_is_busy(state_q);
    assign bus.done      = (state_q == S_DONE);
    assign bus.in_ready  = in_ready;
    assign bus.pipe_en   = pipe_en;
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;

endmodule

// File: tb/tb_output_pipeline_ctrl.sv
// Bench for output_pipeline_ctrl: Stages=5 and Stages=1 instances share one
// stimulus stream and are checked every cycle against a queue-of-ages model.
module tb_output_pipeline_ctrl;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          aclr_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] cfg_count = '0;

    always #5 clk = ~clk;

    output_pipeline_ctrl_if #(.CountWidth(CW)) b5 ();
    output_pipeline_ctrl_if #(.CountWidth(CW)) b1 ();

    assign b5.start = start;  assign b5.cfg_count = cfg_count;
    assign b5.in_valid = in_valid;  assign b5.out_ready = out_ready;
    assign b1.start = start;  assign b1.cfg_count = cfg_count;
    assign b1.in_valid = in_valid;  assign b1.out_ready = out_ready;

    output_pipeline_ctrl #(.Stages(5), .CountWidth(CW)) dut5 (
        .clk(clk), .aclr_n(aclr_n), .bus(b5));
    output_pipeline_ctrl #(.Stages(1), .CountWidth(CW)) dut1 (
        .clk(clk), .aclr_n(aclr_n), .bus(b1));

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 run, 2 flush, 3 done; each in-flight result
    // carries the number of pipeline enables it has seen.
    int ph[2], mcfg[2], macc[2], mout[2], qn[2];
    int age[2][64];
    logic [5:0] gv[2];

    typedef struct {
        logic          st;
        logic [CW-1:0] cfg;
        logic          iv;
        logic          ordy;
        logic [5:0]    exp;   // {in_ready, pipe_en, out_valid, out_last, busy, done}
    } vec_t;
    vec_t tbl[14];

    function automatic logic [5:0] dut_out(int d);
        if (d == 0) return {b5.in_ready, b5.pipe_en, b5.out_valid, b5.out_last, b5.busy, b5.done};
        return {b1.in_ready, b1.pipe_en, b1.out_valid, b1.out_last, b1.busy, b1.done};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset_one(input int d);
        ph[d] = 0; mcfg[d] = 0; macc[d] = 0; mout[d] = 0; qn[d] = 0;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) model_reset_one(d);
    endtask

    // One clock: compare both DUTs mid-cycle, advance the model, return #1 after the edge.
    task automatic step();
        bit ov, adv, ir, pe, ol, ihs, ohs;
        int s;
        logic [5:0] e;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            s   = (d == 0) ? 5 : 1;
            ov  = (qn[d] > 0) && (age[d][0] == s);
            adv = !ov || out_ready;
            ir  = (ph[d] == 1) && adv && (macc[d] < mcfg[d]);
            pe  = ((ph[d] == 1) && adv) || ((ph[d] == 2) && adv && (qn[d] > 0));
            ol  = ov && (mout[d] == mcfg[d] - 1);
            e   = {ir, pe, ov, ol, (ph[d] == 1) || (ph[d] == 2), ph[d] == 3};
            gv[d] = dut_out(d);
            chk((d == 0) ? "cyc_s5" : "cyc_s1", 32'(gv[d]), 32'(e));
            ihs = ir && in_valid;
            ohs = ov && out_ready;
            if (!aclr_n) begin
                model_reset_one(d);
            end else begin
                if (ohs) begin
                    for (int k = 0; k < qn[d] - 1; k++) age[d][k] = age[d][k+1];
                    qn[d]--;
                end
                if (pe) for (int k = 0; k < qn[d]; k++) age[d][k]++;
                if (ihs) begin age[d][qn[d]] = 1; qn[d]++; end
                case (ph[d])
                    0: if (start) begin
                           mcfg[d] = int'(cfg_count); macc[d] = 0; mout[d] = 0;
                           ph[d] = (cfg_count != 0) ? 1 : 3;
                       end
                    1: if (ohs && ol) ph[d] = 3; else if (macc[d] == mcfg[d]) ph[d] = 2;
                    2: if (ohs && ol) ph[d] = 3;
                    default: ph[d] = 0;
                endcase
                macc[d] += int'(ihs);
                mout[d] += int'(ohs);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ivm: 0 always valid, 1 alternating 1,0,1..., 2 random.
    // orm: 0 always ready, 1 random, 2 four-cycle stall after the first tail result.
    task automatic frame(input int cfg, input int ivm, input int orm, input bit restart, input string nm);
        int cyc, stall;
        int nh[2];
        bit dn[2];
        bit seen_ov;
        start = 1'b1; cfg_count = CW'(cfg); in_valid = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        cyc = 0; stall = 0; seen_ov = 1'b0;
        nh[0] = 0; nh[1] = 0; dn[0] = 1'b0; dn[1] = 1'b0;
        while (!(dn[0] && dn[1]) && cyc < 400) begin
            case (ivm)
                0: in_valid = 1'b1;
                1: in_valid = (cyc % 2 == 0);
                default: in_valid = ($urandom % 4) != 0;
            endcase
            case (orm)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom % 3) != 0;
                default: begin
                    if (seen_ov && stall < 4) begin out_ready = 1'b0; stall++; end
                    else out_ready = 1'b1;
                end
            endcase
            start = restart && (cfg > 0) && (cyc == 2);
            cfg_count = start ? CW'(7) : CW'($urandom_range(0, 15));
            step();
            if (orm == 2 && !out_ready) chk({nm, "_stall_frozen"}, 32'(gv[0][5:4]), 32'd0);
            if (gv[0][3]) seen_ov = 1'b1;
            for (int d = 0; d < 2; d++) begin
                if (gv[d][3] && out_ready) nh[d]++;
                if (gv[d][0]) dn[d] = 1'b1;
            end
            cyc++;
        end
        start = 1'b0;
        chk({nm, "_done_seen"}, 32'(dn[0] && dn[1]), 32'd1);
        chk({nm, "_outs_s5"}, 32'(nh[0]), 32'(cfg));
        chk({nm, "_outs_s1"}, 32'(nh[1]), 32'(cfg));
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        // cfg=3 frame, no backpressure, then a cfg=0 frame
        tbl[0]  = '{1'b1, 16'd3, 1'b1, 1'b1, 6'b000000};
        tbl[1]  = '{1'b0, 16'd3, 1'b1, 1'b1, 6'b110010};
        tbl[2]  = '{1'b0, 16'd3, 1'b1, 1'b1, 6'b110010};
        tbl[3]  = '{1'b0, 16'd3, 1'b1, 1'b1, 6'b110010};
        tbl[4]  = '{1'b0, 16'd3, 1'b1, 1'b1, 6'b010010};
        tbl[5]  = '{1'b0, 16'd3, 1'b1, 1'b1, 6'b010010};
        tbl[6]  = '{1'b0, 16'd3, 1'b1, 1'b1, 6'b011010};
        tbl[7]  = '{1'b0, 16'd3, 1'b1, 1'b1, 6'b011010};
        tbl[8]  = '{1'b0, 16'd3, 1'b1, 1'b1, 6'b011110};
        tbl[9]  = '{1'b0, 16'd3, 1'b1, 1'b1, 6'b000001};
        tbl[10] = '{1'b0, 16'd3, 1'b1, 1'b1, 6'b000000};
        tbl[11] = '{1'b1, 16'd0, 1'b1, 1'b1, 6'b000000};
        tbl[12] = '{1'b0, 16'd0, 1'b1, 1'b1, 6'b000001};
        tbl[13] = '{1'b0, 16'd0, 1'b1, 1'b1, 6'b000000};

        #12;
        chk("reset_s5", 32'(dut_out(0)), 32'd0);
        chk("reset_s1", 32'(dut_out(1)), 32'd0);
        step();
        aclr_n = 1'b1;
        step();

        for (int i = 0; i < 14; i++) begin
            start = tbl[i].st; cfg_count = tbl[i].cfg;
            in_valid = tbl[i].iv; out_ready = tbl[i].ordy;
            step();
            chk($sformatf("vec%0d", i), 32'(gv[0]), 32'(tbl[i].exp));
        end
        start = 1'b0;

        frame(3, 0, 2, 1'b0, "stall4");
        frame(3, 1, 0, 1'b0, "gapped");
        frame(3, 0, 0, 1'b1, "restart_ignored");
        frame(2, 0, 0, 1'b0, "cfg2");
        frame(0, 0, 0, 1'b0, "cfg0");

        // Asynchronous reset while the Stages=5 instance is flushing
        start = 1'b1; cfg_count = 16'd3; in_valid = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        chk("pre_rst_busy_s5", 32'(b5.busy), 32'd1);
        aclr_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_s5", 32'(dut_out(0)), 32'd0);
        chk("async_rst_s1", 32'(dut_out(1)), 32'd0);
        step();
        aclr_n = 1'b1;
        repeat (3) step();
        frame(3, 0, 0, 1'b0, "post_rst");

        for (int f = 0; f < 30; f++)
            frame($urandom_range(0, 9), $urandom_range(0, 2), $urandom_range(0, 2),
                  1'($urandom_range(0, 1)), $sformatf("rnd%0d", f));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
